// File: rtl/panda_pkg.sv
// -----------------------------------------------------------------------------
// panda_pkg
// Shared types and constants for the Panda core front end.
//   fetch_state_e : fetch-address generator FSM states
//   PcStep        : byte distance between consecutive sequential fetches
//   CountWidth    : width of the fetch-unit performance counters
// -----------------------------------------------------------------------------
package panda_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned PcStep     = 4;
  localparam int unsigned CountWidth = 32;

endpackage : panda_pkg

// File: rtl/panda_adder.sv
// -----------------------------------------------------------------------------
// panda_adder
// Generic two's-complement adder/subtractor, modulo 2^Width.
//   operand_a_i : first operand
//   operand_b_i : second operand
//   subtract_i  : 1 -> sum_o = a - b, 0 -> sum_o = a + b
//   sum_o       : result (carry-out discarded)
// -----------------------------------------------------------------------------
module panda_adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);

  // Subtraction as a + ~b + 1.
  assign sum_o = operand_a_i + (operand_b_i ^ {Width{subtract_i}}) + Width'(subtract_i);

endmodule : panda_adder

// File: rtl/panda_fetch_pc.sv
// -----------------------------------------------------------------------------
// panda_fetch_pc
// Fetch-address generator: holds the architectural fetch PC and issues
// requests to instruction memory over a valid/ready handshake.
//
// Parameters:
//   Width       : address width (>= 3)
//   ResetVector : PC after reset (4-byte aligned)
//   NumRedirect : number of redirect sources, index 0 highest priority
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   redirect_valid_i/addr_i: per-source redirect request and target
//   halt_i                 : level request to stop issuing fetches
//   fetch_valid_o/ready_i  : request handshake
//   fetch_addr_o           : registered PC
//   pc_inc_o               : fetch_addr_o + 4
//   misaligned_o           : one-cycle pulse, taken target had addr[1:0] != 0
//   fetch_count_o          : accepted-fetch counter
//   redirect_count_o       : taken-redirect counter
// Configuration:
//   PANDA_FETCH_PERF_EN    : when defined the two counters are implemented,
//                            otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module panda_fetch_pc
  import panda_pkg::*;
#(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] ResetVector = '0,
  parameter int unsigned      NumRedirect = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumRedirect-1:0]            redirect_valid_i,
  input  logic [NumRedirect-1:0][Width-1:0] redirect_addr_i,
  input  logic                              halt_i,
  output logic                              fetch_valid_o,
  input  logic                              fetch_ready_i,
  output logic [Width-1:0]                  fetch_addr_o,
  output logic [Width-1:0]                  pc_inc_o,
  output logic                              misaligned_o,
  output logic [CountWidth-1:0]             fetch_count_o,
  output logic [CountWidth-1:0]             redirect_count_o
);

  fetch_state_e     state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic [Width-1:0] pc_inc;
  logic             handshake;
  logic             redirect_taken;
  logic [Width-1:0] redirect_target;

  // ---------------------------------------------------------------------------
  // Sequential increment through the shared adder.
  // ---------------------------------------------------------------------------
  panda_adder #(
    .Width(Width)
  ) u_pc_adder (
    .operand_a_i(pc_q),
    .operand_b_i(Width'(PcStep)),
    .subtract_i (1'b0),
    .sum_o      (pc_inc)
  );

  // Valid comes straight from the state register, so there is no path
  // from fetch_ready_i or the redirect inputs to fetch_valid_o.
  assign fetch_valid_o = (state_q == FETCH_RUN);
  assign handshake     = fetch_valid_o & fetch_ready_i;

  // ---------------------------------------------------------------------------
  // Fixed-priority redirect selection: scanning from the highest index down
  // leaves the lowest-index valid source as the final assignment.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    redirect_taken  = 1'b0;
    redirect_target = '0;
    for (int i = NumRedirect - 1; i >= 0; i--) begin
      if (redirect_valid_i[i]) begin
        redirect_taken  = 1'b1;
        redirect_target = redirect_addr_i[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, next-PC and misalignment flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;

    unique case (state_q)
      FETCH_BOOT:   state_d = FETCH_RUN;
      FETCH_RUN:    if (halt_i && (handshake || redirect_taken)) state_d = FETCH_HALTED;
      FETCH_HALTED: if (!halt_i) state_d = FETCH_RUN;
      default:      state_d = FETCH_BOOT;
    endcase

    // A redirect wins over the increment even when the current request is
    // accepted in the same cycle; an unaccepted request is simply dropped.
    if (redirect_taken) begin
      pc_d         = {redirect_target[Width-1:2], 2'b00};
      misaligned_d = |redirect_target[1:0];
    end else if (handshake) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FETCH_BOOT;
      pc_q         <= ResetVector;
      misaligned_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement or process order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign fetch_addr_o = pc_q;
  assign pc_inc_o     = pc_inc;
  assign misaligned_o = misaligned_q;

  // ---------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32).
  // ---------------------------------------------------------------------------
`ifdef PANDA_FETCH_PERF_EN
  logic [CountWidth-1:0] fetch_count_q;
  logic [CountWidth-1:0] redirect_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      if (handshake)      fetch_count_q    <= fetch_count_q + 1'b1;
      if (redirect_taken) redirect_count_q <= redirect_count_q + 1'b1;
    end
  end

  assign fetch_count_o    = fetch_count_q;
  assign redirect_count_o = redirect_count_q;
`else
  assign fetch_count_o    = '0;
  assign redirect_count_o = '0;
`endif

endmodule : panda_fetch_pc

// File: tb/tb_panda_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_panda_fetch_pc
// Self-checking bench for panda_fetch_pc (Width=32, ResetVector=0x100,
// NumRedirect=2). Addresses expected to be accepted are queued by each
// scenario; a negedge monitor pops and compares them on every handshake.
// -----------------------------------------------------------------------------
module tb_panda_fetch_pc;

  localparam int unsigned      W   = 32;
  localparam int unsigned      NR  = 2;
  localparam logic [W-1:0]     RV  = 32'h0000_0100;
`ifdef PANDA_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                     clk_i;
  logic                     rst_ni;
  logic [NR-1:0]            redirect_valid_i;
  logic [NR-1:0][W-1:0]     redirect_addr_i;
  logic                     halt_i;
  logic                     fetch_valid_o;
  logic                     fetch_ready_i;
  logic [W-1:0]             fetch_addr_o;
  logic [W-1:0]             pc_inc_o;
  logic                     misaligned_o;
  logic [31:0]              fetch_count_o;
  logic [31:0]              redirect_count_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_fetch = 0;
  logic [31:0]  exp_redir = 0;

  panda_fetch_pc #(
    .Width      (W),
    .ResetVector(RV),
    .NumRedirect(NR)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .redirect_valid_i(redirect_valid_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .fetch_valid_o   (fetch_valid_o),
    .fetch_ready_i   (fetch_ready_i),
    .fetch_addr_o    (fetch_addr_o),
    .pc_inc_o        (pc_inc_o),
    .misaligned_o    (misaligned_o),
    .fetch_count_o   (fetch_count_o),
    .redirect_count_o(redirect_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: a handshake visible at negedge is accepted at the
  // following rising edge; its address must match the oldest queued entry.
  always @(negedge clk_i) begin
    if (rst_ni && fetch_valid_o && fetch_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: accepted addr %h, expected no request", fetch_addr_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (fetch_addr_o !== e) begin
          errors++;
          $display("FAIL sb_addr: accepted %h expected %h", fetch_addr_o, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_fetch(input logic [W-1:0] a);
    exp_q.push_back(a);
    exp_fetch++;
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (fetch_count_o !== (PERF ? exp_fetch : 32'd0)) begin
      errors++;
      $display("FAIL %s_fetch_count: got %0d expected %0d", tag, fetch_count_o, PERF ? exp_fetch : 32'd0);
    end
    checks++;
    if (redirect_count_o !== (PERF ? exp_redir : 32'd0)) begin
      errors++;
      $display("FAIL %s_redirect_count: got %0d expected %0d", tag, redirect_count_o, PERF ? exp_redir : 32'd0);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [W-1:0] addr);
    checks++;
    if (fetch_valid_o !== valid) begin
      errors++;
      $display("FAIL %s_valid: got %b expected %b", tag, fetch_valid_o, valid);
    end
    checks++;
    if (fetch_addr_o !== addr) begin
      errors++;
      $display("FAIL %s_addr: got %h expected %h", tag, fetch_addr_o, addr);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) step();
    check_out("reset", 1'b0, 32'h100);
    checks++;
    if (pc_inc_o !== 32'h104) begin
      errors++;
      $display("FAIL reset_pc_inc: got %h expected %h", pc_inc_o, 32'h104);
    end
    checks++;
    if (misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_misaligned: got %b expected 0", misaligned_o);
    end
    check_counts("reset");
    rst_ni = 1'b1;
    check_out("boot", 1'b0, 32'h100);
  endtask

  task automatic test_sequential();
    fetch_ready_i = 1'b1;
    expect_fetch(32'h100);
    expect_fetch(32'h104);
    step();
    check_out("seq0", 1'b1, 32'h100);
    step();
    check_out("seq1", 1'b1, 32'h104);
    step();
    fetch_ready_i = 1'b0;
    check_out("seq2", 1'b1, 32'h108);
    check_counts("seq");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 1'b1, 32'h108);
    end
    expect_fetch(32'h108);
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    check_out("stall_release", 1'b1, 32'h10C);
  endtask

  task automatic test_redirect_priority();
    redirect_valid_i   = 2'b11;
    redirect_addr_i[0] = 32'h2000;
    redirect_addr_i[1] = 32'h3000;
    fetch_ready_i      = 1'b1;
    expect_fetch(32'h10C);
    exp_redir++;
    step();
    redirect_valid_i = '0;
    fetch_ready_i    = 1'b0;
    check_out("prio", 1'b1, 32'h2000);
    checks++;
    if (misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL prio_misaligned: got %b expected 0", misaligned_o);
    end
    check_counts("prio");
  endtask

  task automatic test_misaligned();
    redirect_valid_i   = 2'b10;
    redirect_addr_i[1] = 32'h4003;
    exp_redir++;
    step();
    redirect_valid_i = '0;
    check_out("misal", 1'b1, 32'h4000);
    checks++;
    if (misaligned_o !== 1'b1) begin
      errors++;
      $display("FAIL misal_pulse: got %b expected 1", misaligned_o);
    end
    step();
    checks++;
    if (misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL misal_clear: got %b expected 0", misaligned_o);
    end
    check_counts("misal");
  endtask

  task automatic test_halt();
    halt_i = 1'b1;
    step();
    check_out("halt_wait0", 1'b1, 32'h4000);
    step();
    check_out("halt_wait1", 1'b1, 32'h4000);
    expect_fetch(32'h4000);
    fetch_ready_i = 1'b1;
    step();
    check_out("halted", 1'b0, 32'h4004);
    step();
    check_out("halted_hold", 1'b0, 32'h4004);
    redirect_valid_i   = 2'b01;
    redirect_addr_i[0] = 32'h500;
    exp_redir++;
    step();
    redirect_valid_i = '0;
    check_out("halted_redir", 1'b0, 32'h500);
    halt_i = 1'b0;
    expect_fetch(32'h500);
    step();
    check_out("resume", 1'b1, 32'h500);
    step();
    fetch_ready_i = 1'b0;
    check_out("resume_next", 1'b1, 32'h504);
    check_counts("halt");
  endtask

  task automatic test_wrap();
    redirect_valid_i   = 2'b01;
    redirect_addr_i[0] = 32'hFFFF_FFFC;
    exp_redir++;
    step();
    redirect_valid_i = '0;
    check_out("wrap_top", 1'b1, 32'hFFFF_FFFC);
    checks++;
    if (pc_inc_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc_inc: got %h expected 0", pc_inc_o);
    end
    expect_fetch(32'hFFFF_FFFC);
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    check_out("wrap", 1'b1, 32'h0);
    check_counts("wrap");
  endtask

  task automatic test_reset_mid_stall();
    rst_ni = 1'b0;
    #1;
    exp_fetch = 0;
    exp_redir = 0;
    check_out("midrst", 1'b0, RV);
    checks++;
    if (misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_misaligned: got %b expected 0", misaligned_o);
    end
    check_counts("midrst");
    step();
    rst_ni = 1'b1;
    step();
    check_out("midrst_run", 1'b1, RV);
  endtask

  initial begin
    rst_ni           = 1'b0;
    redirect_valid_i = '0;
    redirect_addr_i  = '0;
    halt_i           = 1'b0;
    fetch_ready_i    = 1'b0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_misaligned();
    test_halt();
    test_wrap();
    test_reset_mid_stall();

    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d queued fetches never accepted, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_panda_fetch_pc
